// File: rtl/m_lsu_if.sv
// Wishbone-classic data bus between the load/store unit (master) and memory (slave).
interface m_lsu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_adr_o;
  logic [XLEN-1:0] mem_dat_o;
  logic [3:0]      mem_sel_o;
  logic            mem_we_o;
  logic            mem_cyc_o;
  logic            mem_stb_o;
  logic            mem_ack_i;
  logic            mem_err_i;
  logic [XLEN-1:0] mem_dat_i;

  modport master (
    output mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_cyc_o, mem_stb_o,
    input  mem_ack_i, mem_err_i, mem_dat_i
  );

  modport slave (
    input  mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_cyc_o, mem_stb_o,
    output mem_ack_i, mem_err_i, mem_dat_i
  );
endinterface

// File: rtl/m_lsu.sv
// M-stage load/store bus master: issues one Wishbone access per request,
// stalls the pipeline until it ends, and returns aligned/extended load data.
module m_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] mem_dat_i_w,
  output logic            misalign,
  output logic            bus_err,
  output logic            timeout,
  m_lsu_if.master         bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 11 is never legal.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_misaligned = 1'b0;
      2'b01:   f_misaligned = lo[0];
      2'b10:   f_misaligned = (lo != 2'b00);
      default: f_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_sel = 4'b0001 << lo;
      2'b01:   f_sel = 4'b0011 << {lo[1], 1'b0};
      2'b10:   f_sel = 4'b1111;
      default: f_sel = 4'b0000;
    endcase
  endfunction

  // Replicate store data across lanes so the slave can pick any selected lane.
  function automatic logic [XLEN-1:0] f_wdat(input logic [1:0] size, input logic [XLEN-1:0] wd);
    case (size)
      2'b00:   f_wdat = {4{wd[7:0]}};
      2'b01:   f_wdat = {2{wd[15:0]}};
      default: f_wdat = wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] rd, input logic [1:0] lo,
                                                  input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] sh;
    sh = rd >> {lo, 3'b000};
    case (size)
      2'b00:   f_load_ext = uns ? {{(XLEN-8){1'b0}}, sh[7:0]}  : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'b01:   f_load_ext = uns ? {{(XLEN-16){1'b0}}, sh[15:0]} : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: f_load_ext = sh;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic [XLEN-1:0] dat_o_q, dat_o_d;
  logic [3:0]      sel_q, sel_d;
  logic [1:0]      size_q, size_d;
  logic [1:0]      lo_q, lo_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;
  logic            timeout_q, timeout_d;

  assign stall          = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUS);
  assign done           = done_q;
  assign misalign       = misalign_q;
  assign bus_err        = bus_err_q;
  assign timeout        = timeout_q;
  assign mem_dat_i_w    = rdata_q;
  assign bus.mem_cyc_o  = cyc_q;
  assign bus.mem_stb_o  = cyc_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_adr_o  = adr_q;
  assign bus.mem_sel_o  = sel_q;
  assign bus.mem_dat_o  = dat_o_q;

  // Next-state and next-output computation for the IDLE/BUS/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_o_d    = dat_o_q;
    sel_d      = sel_q;
    size_d     = size_q;
    lo_d       = lo_q;
    uns_d      = uns_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (f_misaligned(req_size, req_addr[1:0])) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = {XLEN{1'b0}};
          end else begin
            state_d = S_BUS;
            cnt_d   = {CW{1'b0}};
            cyc_d   = 1'b1;
            we_d    = req_we;
            adr_d   = {req_addr[XLEN-1:2], 2'b00};
            sel_d   = f_sel(req_size, req_addr[1:0]);
            dat_o_d = f_wdat(req_size, req_wdata);
            size_d  = req_size;
            lo_d    = req_addr[1:0];
            uns_d   = req_unsigned;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        if (bus.mem_err_i) begin
          state_d   = S_DONE;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          rdata_d   = {XLEN{1'b0}};
        end else if (bus.mem_ack_i) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = f_load_ext(bus.mem_dat_i, lo_q, size_q, uns_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = {XLEN{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // The pipeline advances at the end of this cycle; a held req_valid is not a new request.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= {XLEN{1'b0}};
      dat_o_q    <= {XLEN{1'b0}};
      sel_q      <= 4'b0000;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      uns_q      <= 1'b0;
      rdata_q    <= {XLEN{1'b0}};
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_o_q    <= dat_o_d;
      sel_q      <= sel_d;
      size_q     <= size_d;
      lo_q       <= lo_d;
      uns_q      <= uns_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_m_lsu.sv
// Directed self-checking bench for m_lsu with a 4-cycle slave timeout.
module tb_m_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] mem_dat_i_w;
  logic        misalign;
  logic        bus_err;
  logic        timeout;

  int checks   = 0;
  int failures = 0;
  int stall_cnt;

  m_lsu_if #(.XLEN(32)) bus_if ();

  m_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .mem_dat_i_w  (mem_dat_i_w),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .timeout      (timeout),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Move to the start of the next cycle (just after the rising edge).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_if.mem_ack_i = 1'b0; bus_if.mem_err_i = 1'b0; bus_if.mem_dat_i = 32'h0;

    // Reset state; stall follows req_valid while held in reset.
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sel", {28'd0, bus_if.mem_sel_o}, 32'd0);
    chk("rst_rdata", mem_dat_i_w, 32'h0);
    req_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // lb 0x1003, zero-wait ack with 0x80FF_1234
    tick();
    req(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
    @(negedge clk);
    chk("lb_c1_stall", {31'd0, stall}, 32'd1);
    chk("lb_c1_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_dat_i = 32'h80FF_1234;
    @(negedge clk);
    chk("lb_c2_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd1);
    chk("lb_c2_stb", {31'd0, bus_if.mem_stb_o}, 32'd1);
    chk("lb_c2_sel", {28'd0, bus_if.mem_sel_o}, 32'h8);
    chk("lb_c2_adr", bus_if.mem_adr_o, 32'h0000_1000);
    chk("lb_c2_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_if.mem_ack_i = 1'b0; bus_if.mem_dat_i = 32'h0;
    @(negedge clk);
    chk("lb_c3_done", {31'd0, done}, 32'd1);
    chk("lb_c3_stall", {31'd0, stall}, 32'd0);
    chk("lb_c3_rdata", mem_dat_i_w, 32'hFFFF_FF80);
    chk("lb_c3_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("lb_no_reissue", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    chk("lb_done_pulse", {31'd0, done}, 32'd0);

    // lhu 0x2002, ack after 3 wait cycles (ack coincides with last counter value)
    stall_cnt = 0;
    tick();
    req(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0);
    @(negedge clk);
    stall_cnt += int'(stall);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      stall_cnt += int'(stall);
      chk("lhu_wait_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd1);
      chk("lhu_wait_sel", {28'd0, bus_if.mem_sel_o}, 32'hC);
    end
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_dat_i = 32'hBEEF_0000;
    @(negedge clk);
    stall_cnt += int'(stall);
    tick();
    bus_if.mem_ack_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    stall_cnt += int'(stall);
    chk("lhu_done", {31'd0, done}, 32'd1);
    chk("lhu_no_timeout", {31'd0, timeout}, 32'd0);
    chk("lhu_rdata", mem_dat_i_w, 32'h0000_BEEF);
    chk("lhu_stall_cycles", stall_cnt, 32'd5);

    // sb 0x1001 with 0x1234_56AB; load data register must keep its value
    tick();
    req(1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h1234_56AB);
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("sb_we", {31'd0, bus_if.mem_we_o}, 32'd1);
    chk("sb_sel", {28'd0, bus_if.mem_sel_o}, 32'h2);
    chk("sb_dat_o", bus_if.mem_dat_o, 32'hABAB_ABAB);
    chk("sb_adr", bus_if.mem_adr_o, 32'h0000_1000);
    tick();
    bus_if.mem_ack_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_rdata_kept", mem_dat_i_w, 32'h0000_BEEF);

    // lw 0x1002 misaligned: no bus cycle, done+misalign in cycle 2
    tick();
    req(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0);
    @(negedge clk);
    chk("mis_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    chk("mis_done", {31'd0, done}, 32'd1);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_rdata", mem_dat_i_w, 32'h0);

    // lw 0x3000 normal, sets a nonzero result
    tick();
    req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_dat_i = 32'h1122_3344;
    @(negedge clk);
    chk("lw_sel", {28'd0, bus_if.mem_sel_o}, 32'hF);
    tick();
    bus_if.mem_ack_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("lw_rdata", mem_dat_i_w, 32'h1122_3344);

    // lw 0x3004, slave silent: 4 BUS cycles, then timeout
    tick();
    req(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("to_bus_cyc", {31'd0, bus_if.mem_cyc_o}, 32'd1);
      chk("to_bus_nodone", {31'd0, done}, 32'd0);
    end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    chk("to_cyc_low", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    chk("to_rdata", mem_dat_i_w, 32'h0);

    // lh 0x4002 signed, ack with 0x8001_0000
    tick();
    req(1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0);
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_dat_i = 32'h8001_0000;
    tick();
    bus_if.mem_ack_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("lh_rdata", mem_dat_i_w, 32'hFFFF_8001);

    // lbu 0x4001 with err and ack together: err wins, data zeroed
    tick();
    req(1'b0, 2'b00, 1'b1, 32'h0000_4001, 32'h0);
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_err_i = 1'b1; bus_if.mem_dat_i = 32'h0000_7F00;
    tick();
    bus_if.mem_ack_i = 1'b0; bus_if.mem_err_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("err_done", {31'd0, done}, 32'd1);
    chk("err_flag", {31'd0, bus_err}, 32'd1);
    chk("err_rdata", mem_dat_i_w, 32'h0);

    // Reset during BUS: cyc drops asynchronously, no done afterwards
    tick();
    req(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0);
    tick();
    #1;
    chk("rstmid_cyc_before", {31'd0, bus_if.mem_cyc_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cyc_async", {31'd0, bus_if.mem_cyc_o}, 32'd0);
    chk("rstmid_stb_async", {31'd0, bus_if.mem_stb_o}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_nodone", {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_nodone2", {31'd0, done}, 32'd0);
    chk("rstmid_idle", {31'd0, bus_if.mem_cyc_o}, 32'd0);

    // Following lw completes normally
    tick();
    req(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0);
    tick();
    bus_if.mem_ack_i = 1'b1; bus_if.mem_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("post_adr", bus_if.mem_adr_o, 32'h0000_5004);
    tick();
    bus_if.mem_ack_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_done", {31'd0, done}, 32'd1);
    chk("post_rdata", mem_dat_i_w, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
